adc_sample_averager: RTL and testbench

//  Consumes the 12-bit ADC samples produced by the MCP3221 I2C master.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_result_fifo.sv | 57 +++++
 rtl/adc_sample_averager.sv | 204 ++++++++++++++++++++
 tb/tb_adc_sample_averager.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types for the ADC sample averager: sample width, FSM states and the
// per-window result record stored in the result FIFO.
// Build option: ADC_AVG_MINMAX_EN adds min/max fields to adc_result_t.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_SEQ_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } avg_state_t;

    typedef struct packed {
        logic [ADC_DATA_W-1:0] avg;
`ifdef ADC_AVG_MINMAX_EN
        logic [ADC_DATA_W-1:0] min;
        logic [ADC_DATA_W-1:0] max;
`endif
        logic [ADC_SEQ_W-1:0]  seq;
    } adc_result_t;

endpackage

// File: rtl/adc_result_fifo.sv
// Show-ahead FIFO of adc_result_t. The head entry is visible on 'head' as soon
// as it is stored; 'head' reads as zero while empty. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. 'flush' empties the FIFO
// synchronously and discards any push in that cycle.
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  adc_result_t            push_data,
    input  logic                   pop,
    output adc_result_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    adc_result_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because 'head' is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_sample_averager.sv
// Window averager for MCP3221 ADC samples. Sums 2**LOG2_WIN samples, then
// writes {avg, min, max, seq} into a show-ahead result FIFO.
// Build option: ADC_AVG_MINMAX_EN enables min/max tracking; without it
// out_min/out_max are tied to zero and no min/max state exists.
//
// Output handshake: out_valid is high whenever the FIFO holds an entry and the
// out_* fields show that entry; the entry is consumed on a rising clock edge
// where out_valid && out_ready. out_valid never waits on out_ready. The sample
// input has no backpressure: every cycle with sample_valid high is one sample.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_WIN   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           sample_in,
    input  logic                        sample_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_avg,
    output logic [DATA_W-1:0]           out_min,
    output logic [DATA_W-1:0]           out_max,
    output logic [7:0]                  out_seq,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output avg_state_t                  state_dbg
);

    localparam int ACC_W = DATA_W + LOG2_WIN;

    avg_state_t          state;
    avg_state_t          state_nxt;
    logic [ACC_W-1:0]    acc;
    logic [LOG2_WIN-1:0] cnt;
    logic [7:0]          seq;
    logic                last_sample;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    adc_result_t         push_data;
    adc_result_t         head;

    // cnt counts accepted samples modulo the window; all-ones means this is the last one.
    assign last_sample = sample_valid && (&cnt);
    assign fifo_pop    = out_ready && !fifo_empty;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and FIFO write strobe; clear suppresses the write of a finished window.
    always_comb begin
        state_nxt = state;
        fifo_push = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = ACCUM;
                ACCUM: begin
                    if (!enable)          state_nxt = IDLE;
                    else if (last_sample) state_nxt = PUSH;
                end
                PUSH: begin
                    fifo_push = 1'b1;
                    state_nxt = enable ? ACCUM : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Accumulator, window counter, sequence number and sticky overflow.
    // In PUSH the FIFO is written from the completed sum while a concurrent
    // sample seeds the next window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            cnt      <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            cnt      <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (!enable) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (sample_valid) begin
                        acc <= acc + ACC_W'(sample_in);
                        cnt <= cnt + 1'b1;
                    end
                end
                PUSH: begin
                    seq <= seq + 8'd1;
                    if (fifo_full && !fifo_pop) overflow <= 1'b1;
                    if (enable && sample_valid) begin
                        acc <= ACC_W'(sample_in);
                        cnt <= LOG2_WIN'(1);
                    end else begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: begin
                    acc <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;

    // Running min/max of the current window; starts at all-ones / zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_min <= '1;
            win_max <= '0;
        end else if (clear) begin
            win_min <= '1;
            win_max <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (!enable) begin
                        win_min <= '1;
                        win_max <= '0;
                    end else if (sample_valid) begin
                        if (sample_in < win_min) win_min <= sample_in;
                        if (sample_in > win_max) win_max <= sample_in;
                    end
                end
                PUSH: begin
                    if (enable && sample_valid) begin
                        win_min <= sample_in;
                        win_max <= sample_in;
                    end else begin
                        win_min <= '1;
                        win_max <= '0;
                    end
                end
                default: begin
                    win_min <= '1;
                    win_max <= '0;
                end
            endcase
        end
    end
`endif

    // Result record assembled from the completed window (truncating average).
    always_comb begin
        push_data     = '0;
        push_data.avg = acc[ACC_W-1:LOG2_WIN];
        push_data.seq = seq;
`ifdef ADC_AVG_MINMAX_EN
        push_data.min = win_min;
        push_data.max = win_max;
`endif
    end

    adc_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign out_avg   = head.avg;
    assign out_seq   = head.seq;
    assign state_dbg = state;
`ifdef ADC_AVG_MINMAX_EN
    assign out_min   = head.min;
    assign out_max   = head.max;
`else
    assign out_min   = '0;
    assign out_max   = '0;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager. Samples are grouped into windows
// by a queue-based reference model; completed windows land in exp_q unless the
// model FIFO is full, in which case the model overflow flag is set.
`timescale 1ns/1ps
module tb_adc_sample_averager;
    import adc_pkg::*;

    localparam int WIN   = 16;
    localparam int DEPTH = 8;
    localparam int RW    = 44;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [11:0] out_avg;
    logic [11:0] out_min;
    logic [11:0] out_max;
    logic [7:0]  out_seq;
    logic [3:0]  fifo_level;
    logic        overflow;
    avg_state_t  state_dbg;

    always #5 clk = ~clk;

    adc_sample_averager #(
        .DATA_W     (12),
        .LOG2_WIN   (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear        (clear),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_avg      (out_avg),
        .out_min      (out_min),
        .out_max      (out_max),
        .out_seq      (out_seq),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [RW-1:0] exp_q[$];
    int unsigned win_q[$];
    int unsigned m_seq = 0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [RW-1:0] window_result(input int unsigned seqv);
        int unsigned sum = 0;
        int unsigned mn  = 4095;
        int unsigned mx  = 0;
        foreach (win_q[i]) begin
            sum += win_q[i];
            if (win_q[i] < mn) mn = win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
        end
`ifndef ADC_AVG_MINMAX_EN
        mn = 0;
        mx = 0;
`endif
        return {12'(sum / WIN), 12'(mn), 12'(mx), 8'(seqv)};
    endfunction

    task automatic model_accept(input logic [11:0] v);
        win_q.push_back(32'(v));
        if (win_q.size() == WIN) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(window_result(m_seq));
            else                      m_ovf = 1'b1;
            m_seq = (m_seq + 1) % 256;
            win_q.delete();
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        win_q.delete();
        m_seq = 0;
        m_ovf = 1'b0;
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_sample(input logic [11:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        model_accept(v);
    endtask

    task automatic send_const(input int n, input logic [11:0] v);
        for (int i = 0; i < n; i++) send_sample(v);
    endtask

    task automatic send_random(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            send_sample(12'($urandom_range(0, 4095)));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic drain_all(input string tag);
        logic [RW-1:0] e;
        int t;
        @(negedge clk);
        check({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        while (exp_q.size() > 0) begin
            t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (!out_valid) begin
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check({tag, "_avg"}, 32'(out_avg), 32'(e[43:32]));
            check({tag, "_min"}, 32'(out_min), 32'(e[31:20]));
            check({tag, "_max"}, 32'(out_max), 32'(e[19:8]));
            check({tag, "_seq"}, 32'(out_seq), 32'(e[7:0]));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        @(negedge clk);
        // reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_avg", 32'(out_avg), 32'd0);
        check("rst_seq", 32'(out_seq), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // constant window with latency check
        send_const(WIN, 12'h100);
        check("t1_lat_k", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_k1", 32'(out_valid), 32'd1);
        check("t1_avg_direct", 32'(out_avg), 32'h100);
        drain_all("t1");

        // ramp 0..15
        for (int i = 0; i < WIN; i++) send_sample(12'(i));
        drain_all("t2");

        // full-scale window, accumulator must not wrap
        send_const(WIN, 12'hFFF);
        drain_all("t3");

        // random windows with idle gaps
        for (int r = 0; r < 4; r++) begin
            send_random(WIN * $urandom_range(1, 3), 1'b1);
            drain_all("rnd");
        end

        // overflow: nine windows with no consumer
        do_clear();
        send_random(WIN * 9, 1'b0);
        @(negedge clk);
        check("t4_level_full", 32'(fifo_level), 32'd8);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        drain_all("t4");
        do_clear();
        check("t4_ovf_clr", 32'(overflow), 32'd0);

        // partial window discarded by enable=0
        send_random(5, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        win_q.delete();
        enable = 1'b1;
        @(negedge clk);
        send_const(WIN, 12'h010);
        drain_all("t5");

        // async reset mid-window with a result pending
        send_random(WIN, 1'b0);
        send_random(5, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_level", 32'(fifo_level), 32'd0);
        check("ar_avg", 32'(out_avg), 32'd0);
        check("ar_seq", 32'(out_seq), 32'd0);
        check("ar_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);

        // back-to-back windows: first sample of B arrives during PUSH of A
        send_random(WIN, 1'b0);
        send_const(WIN, 12'h020);
        drain_all("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
